uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. Byte input uses a valid/ready stream handshake into an internal FIFO. Frame format is runtime-configurable: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits. The baud divider is internal, so no external baud-generator handshake is needed; the block sits between the host bus/stream logic and the tx pin.

Parameters:
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2
DIV_W, 16, width of the baud divisor input

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_valid  in  1  input byte valid
s_ready  out  1  FIFO can accept a byte (= !full, registered)
s_data  in  8  byte to send; bits above the configured data width are ignored
cfg_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity  in  2  00=none, 01=even, 10=odd, 11=none (reserved)
cfg_stop2  in  1  0=1 stop bit, 1=2 stop bits
baud_div  in  DIV_W  bit period minus one, in clk cycles; 0 gives a 1-cycle bit
tx  out  1  serial line, idle high, registered
busy  out  1  frame in progress
done  out  1  1-cycle pulse at frame end
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: tx=1, busy=0, done=0, s_ready=1, fifo_level=0. FIFO pointers, bit counter and baud counter are all zero.
- Reset mid-frame aborts the frame and flushes the FIFO. tx returns high on the next edge; done does not pulse.
- Push: occurs when s_valid && s_ready at a clock edge. s_ready depends only on the registered count; there is no combinational bypass.
- When full, s_ready=0 and input data is held off. A push and a pop on the same edge leave fifo_level unchanged.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when the FIFO is non-empty. On that transition:
  - pop the head byte into the shift register;
  - latch cfg_data_bits, cfg_parity, cfg_stop2 and baud_div for the whole frame (changes mid-frame take effect next frame);
  - precompute parity over the used data bits only: even = XOR, odd = ~XOR.
- Bit timing: every bit lasts exactly baud_div+1 cycles. A down-counter reloads at each bit boundary.
- START: tx=0 for one bit period.
- DATA: LSB first. Shift right once per bit period; emit exactly N data bits.
- PARITY: entered only if parity is enabled; one bit period.
- STOP: tx=1 for 1 or 2 bit periods.
- Frame length is (1 + N + P + S) * (baud_div+1) cycles.
- Latency: a byte accepted into an empty FIFO while IDLE at edge E drives tx low after edge E+2.
- busy=1 from the first start-bit cycle through the last stop-bit cycle.
- At the end of the last stop-bit cycle, done pulses for 1 cycle.
  - If the FIFO is non-empty, go STOP -> START directly: no idle gap, busy stays 1, done still pulses.
  - Otherwise go to IDLE: tx=1, busy=0.

Decomposition:
- Package uart_pkg holds:
  - state encodings (IDLE, START, DATA, PARITY, STOP);
  - cfg_parity codes PAR_NONE, PAR_EVEN, PAR_ODD;
  - the cfg_data_bits-to-count mapping function.
- One sub-module: uart_fifo_sync, a synchronous FIFO with FIFO_DEPTH/width-8 parameters and push/pop/full/empty/level ports. It is reused later by the RX path.

Test Plan:
- 8N1, baud_div=3, push 0x55 -> tx low after accept+2 edges; tx holds each bit 4 cycles with sequence 0,1,0,1,0,1,0,1,0,1; 40 cycles total; done pulses once; busy=1 for 40 cycles.
- 7E1 (cfg_data_bits=10, cfg_parity=01), baud_div=0, push 0x41 -> tx 0,1,0,0,0,0,0,1,0,1 at one cycle per bit.
- 8O2, baud_div=1, push 0xA5 -> tx 0,1,0,1,0,0,1,0,1,1,1,1 with each bit 2 cycles; 24 cycles total.
- Push 6 bytes back-to-back with FIFO_DEPTH=4 during the first frame -> s_ready drops when fifo_level=4; all 6 bytes are sent in order with no idle gaps; 6 done pulses.
- Change cfg_parity and baud_div mid-frame -> current frame is unaffected; the next frame uses the new settings.
- Assert rst during a DATA bit with 2 bytes queued -> tx=1 after the next edge; busy=0, fifo_level=0, no done pulse; no transmission after rst release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmit path:
// FSM state encoding, parity codes and data-width decoding.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // 00..11 selects 5..8 data bits
   function automatic logic [3:0] data_bits_count(input logic [1:0] code);
      return 4'd5 + {2'b00, code};
   endfunction

endpackage

// File: rtl/uart_fifo_sync.sv
// Single-clock FIFO with first-word-fall-through read; full/empty and
// level come from the registered occupancy count only.
module uart_fifo_sync #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with stream input FIFO and per-frame latched format:
// 5-8 data bits, none/even/odd parity, 1 or 2 stop bits, internal baud divider.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [7:0]                    s_data,
   input  logic [1:0]                    cfg_data_bits,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   input  logic [DIV_W-1:0]              baud_div,
   output logic                          tx,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   logic [7:0]       fifo_rdata;
   logic             fifo_full, fifo_empty, pop;

   state_t           state_q;
   logic [DIV_W-1:0] cnt_q, div_q;
   logic [2:0]       bitcnt_q;
   logic             stop_sec_q;
   logic [7:0]       shift_q;
   logic [3:0]       nbits_q;
   logic             par_en_q, par_q, stop2_q;
   logic             tx_q, busy_q, done_q;

   logic [3:0]       nbits_d;
   logic [7:0]       mask_d;
   logic             par_en_d, par_d;
   logic             bit_end, last_bit, frame_end;

   uart_fifo_sync #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (s_valid),
      .data_i  (s_data),
      .pop_i   (pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign s_ready = !fifo_full;

   // Frame format of the head byte, sampled only when it is popped
   always_comb begin
      nbits_d  = data_bits_count(cfg_data_bits);
      mask_d   = 8'hFF >> (4'd8 - nbits_d);
      par_en_d = 1'b0;
      par_d    = ^(fifo_rdata & mask_d);
      case (cfg_parity)
         PAR_EVEN: par_en_d = 1'b1;
         PAR_ODD: begin
            par_en_d = 1'b1;
            par_d    = ~par_d;
         end
         PAR_NONE: par_en_d = 1'b0;
         default:  par_en_d = 1'b0;
      endcase
   end

   assign bit_end   = (cnt_q == '0);
   assign last_bit  = ({1'b0, bitcnt_q} == (nbits_q - 4'd1));
   assign frame_end = (state_q == ST_STOP) && bit_end && (!stop2_q || stop_sec_q);
   assign pop       = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

   always_ff @(posedge clk) begin
      if (pop) begin
         shift_q  <= fifo_rdata;
         div_q    <= baud_div;
         nbits_q  <= nbits_d;
         par_en_q <= par_en_d;
         par_q    <= par_d;
         stop2_q  <= cfg_stop2;
      end else if (state_q == ST_DATA && bit_end) begin
         shift_q  <= {1'b0, shift_q[7:1]};
      end
   end

   // Outputs are registered from the current state, so the line trails the
   // state by one cycle; this gives the two-edge accept-to-start latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bitcnt_q   <= '0;
         stop_sec_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         busy_q <= (state_q != ST_IDLE);
         done_q <= frame_end;
         case (state_q)
            ST_START:  tx_q <= 1'b0;
            ST_DATA:   tx_q <= shift_q[0];
            ST_PARITY: tx_q <= par_q;
            default:   tx_q <= 1'b1;
         endcase

         if (pop) begin
            state_q    <= ST_START;
            cnt_q      <= baud_div;
            bitcnt_q   <= '0;
            stop_sec_q <= 1'b0;
         end else if (state_q != ST_IDLE && !bit_end) begin
            cnt_q <= cnt_q - DIV_W'(1);
         end else begin
            case (state_q)
               ST_START: begin
                  cnt_q    <= div_q;
                  bitcnt_q <= '0;
                  state_q  <= ST_DATA;
               end
               ST_DATA: begin
                  cnt_q <= div_q;
                  if (last_bit) begin
                     stop_sec_q <= 1'b0;
                     state_q    <= par_en_q ? ST_PARITY : ST_STOP;
                  end else begin
                     bitcnt_q <= bitcnt_q + 3'd1;
                  end
               end
               ST_PARITY: begin
                  cnt_q      <= div_q;
                  stop_sec_q <= 1'b0;
                  state_q    <= ST_STOP;
               end
               ST_STOP: begin
                  if (frame_end) begin
                     state_q <= ST_IDLE;
                  end else begin
                     cnt_q      <= div_q;
                     stop_sec_q <= 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: each pushed byte queues its expected
// line waveform, and a negedge monitor compares it against tx/busy/done.
module tb_uart_tx_cfg;

   localparam int FIFO_DEPTH = 4;
   localparam int DIV_W      = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             s_valid;
   logic             s_ready;
   logic [7:0]       s_data;
   logic [1:0]       cfg_data_bits;
   logic [1:0]       cfg_parity;
   logic             cfg_stop2;
   logic [DIV_W-1:0] baud_div;
   logic             tx, busy, done;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;

   uart_tx_cfg #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop2     (cfg_stop2),
      .baud_div      (baud_div),
      .tx            (tx),
      .busy          (busy),
      .done          (done),
      .fifo_level    (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] bits;
      int          nb;
      int          div;
   } frame_t;

   frame_t exp_q[$];
   int     start_log[$];
   int     n_checks = 0;
   int     n_errors = 0;
   int     tick = 0, done_cnt = 0, busy_cnt = 0;
   bit     saw_full = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // par: 0 none, 1 even, 2 odd
   function automatic frame_t mk(input logic [7:0] d, input int n, input int par,
                                 input int st2, input int div);
      frame_t f;
      int     k;
      logic   x;
      f.bits    = '1;
      f.bits[0] = 1'b0;
      x = 1'b0;
      for (int i = 0; i < n; i++) begin
         f.bits[1+i] = d[i];
         x = x ^ d[i];
      end
      k = 1 + n;
      if (par == 1) begin f.bits[k] = x;  k++; end
      if (par == 2) begin f.bits[k] = ~x; k++; end
      k = k + 1 + st2;
      f.nb  = k;
      f.div = div;
      return f;
   endfunction

   // Monitor: aligns on the start bit, then checks every cycle of the frame
   frame_t cur;
   bit     in_frame = 0;
   int     fcyc = 0, flen = 0;

   always @(negedge clk) begin
      tick++;
      if (rst) begin
         in_frame = 0;
      end else begin
         if (done) done_cnt++;
         if (busy) busy_cnt++;
         if (!in_frame && tx == 1'b0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_start", 32'(tx), 32'd1);
            end else begin
               cur      = exp_q.pop_front();
               in_frame = 1;
               fcyc     = 0;
               flen     = cur.nb * (cur.div + 1);
               start_log.push_back(tick);
            end
         end
         if (in_frame) begin
            check("tx_bit", 32'(tx), 32'(cur.bits[fcyc / (cur.div + 1)]));
            check("busy_frame", 32'(busy), 32'd1);
            check("done_pos", 32'(done), 32'(fcyc == flen - 1));
            fcyc++;
            if (fcyc == flen) in_frame = 0;
         end else begin
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
         end
      end
   end

   task automatic set_cfg(input logic [1:0] db, input logic [1:0] par,
                          input logic st2, input int div);
      cfg_data_bits = db;
      cfg_parity    = par;
      cfg_stop2     = st2;
      baud_div      = DIV_W'(div);
   endtask

   // Called #1 after a posedge; returns #1 after the accepting edge.
   task automatic push_byte(input logic [7:0] d, input int n, input int par,
                            input int st2, input int div);
      bit acc = 0;
      exp_q.push_back(mk(d, n, par, st2, div));
      s_data  = d;
      s_valid = 1'b1;
      for (int w = 0; w < 2000 && !acc; w++) begin
         acc = s_ready;
         if (!s_ready) begin
            check("full_level", 32'(fifo_level), 32'(FIFO_DEPTH));
            saw_full = 1;
         end
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      if (!acc) check("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int max);
      bit ok = 0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         ok = (exp_q.size() == 0) && !busy && (fifo_level == 0);
      end
      if (!ok) check("idle_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_busy(input int max);
      bit ok = 0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         ok = busy;
      end
      if (!ok) check("busy_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   int d0, b0, s0;

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
      set_cfg(2'b11, 2'b00, 1'b0, 3);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready", 32'(s_ready), 32'd1);
      check("rst_level", 32'(fifo_level), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 8N1, divisor 3: latency, 40-cycle frame, single done
      d0 = done_cnt; b0 = busy_cnt;
      exp_q.push_back(mk(8'h55, 8, 0, 0, 3));
      s_data = 8'h55; s_valid = 1'b1;
      @(posedge clk); #1 s_valid = 1'b0;
      @(negedge clk); check("lat_e0", 32'(tx), 32'd1);
      @(negedge clk); check("lat_e1", 32'(tx), 32'd1);
      @(negedge clk); check("lat_e2", 32'(tx), 32'd0);
      wait_idle(200);
      check("t1_done", 32'(done_cnt - d0), 32'd1);
      check("t1_busy", 32'(busy_cnt - b0), 32'd40);

      // 7E1, divisor 0
      set_cfg(2'b10, 2'b01, 1'b0, 0);
      d0 = done_cnt; b0 = busy_cnt;
      push_byte(8'h41, 7, 1, 0, 0);
      wait_idle(100);
      check("t2_done", 32'(done_cnt - d0), 32'd1);
      check("t2_busy", 32'(busy_cnt - b0), 32'd10);

      // 8O2, divisor 1
      set_cfg(2'b11, 2'b10, 1'b1, 1);
      b0 = busy_cnt;
      push_byte(8'hA5, 8, 2, 1, 1);
      wait_idle(100);
      check("t3_busy", 32'(busy_cnt - b0), 32'd24);

      // 5O1, divisor 2: bits above the data width are ignored
      set_cfg(2'b00, 2'b10, 1'b0, 2);
      push_byte(8'hE3, 5, 2, 0, 2);
      wait_idle(100);

      // Six bytes back-to-back into a 4-deep FIFO
      set_cfg(2'b11, 2'b00, 1'b0, 3);
      d0 = done_cnt; saw_full = 0;
      start_log.delete();
      for (int i = 0; i < 6; i++) push_byte(8'h3C + 8'(i * 17), 8, 0, 0, 3);
      wait_idle(600);
      check("t4_saw_full", 32'(saw_full), 32'd1);
      check("t4_done", 32'(done_cnt - d0), 32'd6);
      check("t4_starts", 32'(start_log.size()), 32'd6);
      for (int i = 0; i + 1 < start_log.size(); i++)
         check("t4_gap", 32'(start_log[i+1] - start_log[i]), 32'd40);

      // Format change mid-frame applies to the following frame only
      set_cfg(2'b11, 2'b00, 1'b0, 3);
      push_byte(8'h96, 8, 0, 0, 3);
      push_byte(8'h96, 8, 1, 0, 1);
      wait_busy(50);
      repeat (10) @(posedge clk);
      #1 set_cfg(2'b11, 2'b01, 1'b0, 1);
      wait_idle(300);

      // Reset during a data bit with two bytes still queued
      set_cfg(2'b11, 2'b00, 1'b0, 3);
      push_byte(8'hF0, 8, 0, 0, 3);
      push_byte(8'h0F, 8, 0, 0, 3);
      push_byte(8'hAA, 8, 0, 0, 3);
      wait_busy(50);
      repeat (14) @(posedge clk);
      #1;
      check("t6_queued", 32'(fifo_level), 32'd2);
      d0 = done_cnt; s0 = start_log.size();
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("t6_tx", 32'(tx), 32'd1);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_done", 32'(done), 32'd0);
      check("t6_level", 32'(fifo_level), 32'd0);
      check("t6_ready", 32'(s_ready), 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("t6_no_done", 32'(done_cnt - d0), 32'd0);
      check("t6_no_start", 32'(start_log.size() - s0), 32'd0);
      check("t6_tx_idle", 32'(tx), 32'd1);

      check("end_queue", 32'(exp_q.size()), 32'd0);
      check("end_in_frame", 32'(in_frame), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
